systolic_skew_feeder: RTL
=========================

// Module: systolic_skew_feeder
// PURPOSE
//  Upstream feeder for the systolic PE array: buffers one K-deep tile of signed
//  operand A, one column (N row elements) per beat, then drives the array's
//  left-edge in_a ports with the diagonal skew the systolic array requires.
//  Row r receives element A[r][k] at issue step k+r, and zero at every other step.
//  PEs have no enable and accumulate every cycle, so every idle lane must carry 0.
// PARAMETERS
//  N   4  array rows = number of in_a lanes driven
//  K   4  tile depth = columns of A per tile (K>=1)
//  DW  8  signed element width, matches the PE operand width
// PORTS
//  clk        in   1     clock, all logic on posedge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     in_col holds a valid A column
//  in_ready   out  1     feeder accepts a column; transfer = in_valid&&in_ready
//  in_col     in   N*DW  column k of A; row r at [r*DW +: DW]
//  out_a      out  N*DW  skewed operands to array row r in_a at [r*DW +: DW]
//  out_valid  out  1     out_a carries an issue step of the current tile
//  done       out  1     1-cycle pulse on the last issue step of a tile
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, beat/step counters=0, out_a=0,
//   out_valid=0, done=0. Buffer contents are don't-care. Reset wins over all inputs.
//  FSM IDLE -> LOAD -> ISSUE -> IDLE. in_ready=1 in IDLE and LOAD only
//   (combinational from state); in_valid is ignored in ISSUE.
//  IDLE/LOAD: each handshake writes in_col into buf[beat] and increments beat.
//   The handshake that writes beat K-1 moves to ISSUE with step t=0 and beat=0.
//   For K=1 the move is IDLE->ISSUE directly. in_valid gaps only stall the load.
//  ISSUE: on each edge, register out_a lane r = (t>=r && t-r<K) ? buf[t-r][r] : 0.
//   Set out_valid=1 and t++. On the edge that registers t=K+N-2, also register
//   done=1 and set state=IDLE.
//   Latency: last load beat accepted at edge E0 -> step t appears after edge
//   E(t+1). Total K+N-1 valid cycles.
//  Outside ISSUE steps: out_a=0, out_valid=0, done=0, all registered.
//  Element values pass bit-exact, with no arithmetic or sign change. -128 and 127
//   must survive unchanged.
//  Overlap: in_ready rises while the last step is still on out_a. A beat accepted
//   then writes buf[0] of the next tile. The last step is already registered, so
//   this is safe. Back-to-back tiles cost K load cycles between issue windows.
//  Counters: beat is $clog2(K)+1 bits and t is $clog2(K+N)+1 bits. Neither counter
//   wraps: each is compared against its terminal value and cleared.
//  Reset mid-LOAD or mid-ISSUE: abort the tile, outputs 0 on the next cycle.
//   Next cycle in_ready=1 and a fresh tile loads from beat 0.
// STRUCTURE
//  Shared defines header systolic_defs.vh: DW default, state encodings
//   (S_IDLE, S_LOAD, S_ISSUE), lane-slice macro.
//  One natural sub-module: feeder_tile_buf, a K x N*DW register file with a
//   write port and combinational read of buf[k][r].
//  The FSM, counters and skew mux live in systolic_skew_feeder.
// TESTING (N=4, K=4, DW=8; A[r][k]=10*r+k+1)
//  1 Reset: hold rst 2 cycles -> out_a=0, out_valid=0, done=0, in_ready=1, busy=0.
//  2 Load 4 columns back-to-back -> 7 valid cycles.
//    t0 lanes{1,0,0,0}; t1 {2,11,0,0}; t3 {4,13,22,31}; t6 {0,0,0,34}.
//    done only at t6; out_a=0 after.
//  3 in_valid toggled 1,0,0,1,1,0,1 -> only 4 handshakes load.
//    Output is identical to scenario 2 and begins 1 cycle after the 4th handshake.
//  4 A[0][0]=-128 (8'h80), A[3][3]=127 -> 8'h80 on lane0 at t0, 8'h7F on lane3 at t6.
//  5 rst asserted at step t2 -> next cycle out_a=0, out_valid=0, in_ready=1.
//    A new 4-beat load then reproduces scenario 2.
//  6 in_valid held 1 throughout -> no acceptance during ISSUE.
//    The next tile's beat 0 is accepted on the edge after the t6 step.
//    A second full 7-step window follows correctly.

Source files
------------

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and helpers for the systolic skew feeder.
package systolic_skew_feeder_pkg;

    // Default signed element width, matching the PE operand width
    localparam int unsigned DefDw = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StIssue = 2'd2
    } state_e;

    // LSB position of lane `lane` inside a flat multi-lane vector
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/feeder_tile_buf.sv
// K x N*DW register file holding one operand tile, one column per entry.
// One write port; one combinational read per lane, lane r reads buf[k][r].
module feeder_tile_buf
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned K  = 4,
    parameter int unsigned DW = DefDw,
    parameter int unsigned IW = 2
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [IW-1:0]     i_wr_k,
    input  logic [N*DW-1:0]   i_wr_data,
    input  logic [N*IW-1:0]   i_rd_k,
    output logic [N*DW-1:0]   o_rd_data
);

    logic [N*DW-1:0] r_mem [K];

    // Column write; contents need no reset since every tile is fully reloaded
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_k] <= i_wr_data;
        end
    end

    // Per-lane read: each lane picks its own row element from its own column
    always_comb begin
        o_rd_data = '0;
        for (int r = 0; r < N; r++) begin
            o_rd_data[lane_lsb(r, DW) +: DW] =
                r_mem[i_rd_k[lane_lsb(r, IW) +: IW]][lane_lsb(r, DW) +: DW];
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers one K-deep tile of A columns, then drives the array's left edge with
// the diagonal skew: row r sees A[r][k] at issue step k+r and zero otherwise.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned K  = 4,
    parameter int unsigned DW = DefDw
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   in_col,
    output logic [N*DW-1:0]   out_a,
    output logic              out_valid,
    output logic              done,
    output logic              busy
);

    localparam int unsigned BW = $clog2(K) + 1;
    localparam int unsigned TW = $clog2(K + N) + 1;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [BW-1:0] BeatLast = BW'(K - 1);
    localparam logic [TW-1:0] StepLast = TW'(K + N - 2);

    state_e          r_state, w_state_next;
    logic [BW-1:0]   r_beat, w_beat_next;
    logic [TW-1:0]   r_t, w_t_next;
    logic [N*DW-1:0] r_out_a, w_out_a_next;
    logic            r_out_valid, w_out_valid_next;
    logic            r_done, w_done_next;

    logic            w_hs;
    logic [N-1:0]    w_lane_on;
    logic [N*IW-1:0] w_rd_k;
    logic [N*DW-1:0] w_rd_data;

    assign in_ready  = (r_state != StIssue);
    assign busy      = (r_state != StIdle);
    assign w_hs      = in_valid && in_ready;
    assign out_a     = r_out_a;
    assign out_valid = r_out_valid;
    assign done      = r_done;

    feeder_tile_buf #(
        .N  (N),
        .K  (K),
        .DW (DW),
        .IW (IW)
    ) u_tile_buf (
        .i_clk     (clk),
        .i_wr_en   (w_hs),
        .i_wr_k    (r_beat[IW-1:0]),
        .i_wr_data (in_col),
        .i_rd_k    (w_rd_k),
        .o_rd_data (w_rd_data)
    );

    // Skew decode: lane r is live while r <= t < K+r and then reads column t-r
    always_comb begin
        w_lane_on = '0;
        w_rd_k    = '0;
        for (int r = 0; r < N; r++) begin
            w_lane_on[r] = (r_t >= TW'(r)) && (r_t < TW'(K + r));
            if (w_lane_on[r]) begin
                w_rd_k[lane_lsb(r, IW) +: IW] = IW'(r_t - TW'(r));
            end
        end
    end

    // Next-state, counters and registered outputs; idle lanes always carry zero
    always_comb begin
        w_state_next     = r_state;
        w_beat_next      = r_beat;
        w_t_next         = r_t;
        w_out_a_next     = '0;
        w_out_valid_next = 1'b0;
        w_done_next      = 1'b0;
        unique case (r_state)
            StIdle, StLoad: begin
                if (w_hs) begin
                    if (r_beat == BeatLast) begin
                        w_state_next = StIssue;
                        w_beat_next  = '0;
                        w_t_next     = '0;
                    end else begin
                        w_state_next = StLoad;
                        w_beat_next  = r_beat + BW'(1);
                    end
                end
            end
            StIssue: begin
                for (int r = 0; r < N; r++) begin
                    if (w_lane_on[r]) begin
                        w_out_a_next[lane_lsb(r, DW) +: DW] = w_rd_data[lane_lsb(r, DW) +: DW];
                    end
                end
                w_out_valid_next = 1'b1;
                if (r_t == StepLast) begin
                    w_done_next  = 1'b1;
                    w_state_next = StIdle;
                    w_t_next     = '0;
                end else begin
                    w_t_next = r_t + TW'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
                w_beat_next  = '0;
                w_t_next     = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any tile in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_beat      <= '0;
            r_t         <= '0;
            r_out_a     <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_beat      <= w_beat_next;
            r_t         <= w_t_next;
            r_out_a     <= w_out_a_next;
            r_out_valid <= w_out_valid_next;
            r_done      <= w_done_next;
        end
    end

endmodule
